// File: rtl/itrx_aib_phy_rx_lane_deser.sv
// AIB receive lane deserializer: gathers DDR beat pairs into DWIDTH-bit words,
// hunts for an alignment marker, and delivers aligned words while locked.
module itrx_aib_phy_rx_lane_deser #(
    parameter int                DWIDTH       = 8,
    parameter logic [DWIDTH-1:0] MARKER       = DWIDTH'(8'hA5),
    parameter int                LOCK_TIMEOUT = 16
) (
    input  logic              inclk,
    input  logic              rx_irstb,
    input  logic              rx_en,
    input  logic              odat0,
    input  logic              odat1,
    input  logic              err_clr,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_locked,
    output logic              marker_seen,
    output logic              lock_lost,
    output logic [7:0]        lock_err_cnt
);

    localparam int BW = (DWIDTH / 2 > 1) ? $clog2(DWIDTH / 2) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(DWIDTH / 2 - 1);
    localparam logic [TW-1:0] LAST_TO   = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DWIDTH-1:0] sreg_r;
    logic [BW-1:0]     beat_cnt_r;
    logic [TW-1:0]     timeout_r;
    logic              boundary_s;
    logic              lock_hit_s;
    logic              deliver_s;
    logic              marker_hit_s;
    logic              lost_s;

    // Next-state and per-cycle event decode
    always_comb begin
        state_nxt_s  = state_r;
        lock_hit_s   = 1'b0;
        deliver_s    = 1'b0;
        marker_hit_s = 1'b0;
        lost_s       = 1'b0;
        boundary_s   = (beat_cnt_r == LAST_BEAT);
        if (!rx_en) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_nxt_s = HUNT;
                HUNT: begin
                    if (sreg_r == MARKER) begin
                        state_nxt_s = LOCKED;
                        lock_hit_s  = 1'b1;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                LOCKED: begin
                    // Markers only count at a word boundary; elsewhere they are payload
                    if (boundary_s) begin
                        if (sreg_r == MARKER) begin
                            marker_hit_s = 1'b1;
                        end else begin
                            deliver_s = 1'b1;
                            if (timeout_r == LAST_TO) begin
                                lost_s      = 1'b1;
                                state_nxt_s = HUNT;
                            end else begin
                                state_nxt_s = LOCKED;
                            end
                        end
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, shift register and word-tracking counters
    always_ff @(posedge inclk or negedge rx_irstb) begin
        if (!rx_irstb) begin
            state_r    <= IDLE;
            rx_locked  <= 1'b0;
            sreg_r     <= '0;
            beat_cnt_r <= '0;
            timeout_r  <= '0;
        end else begin
            state_r   <= state_nxt_s;
            rx_locked <= (state_nxt_s == LOCKED);
            if (rx_en) begin
                sreg_r <= {sreg_r[DWIDTH-3:0], odat0, odat1};
            end else begin
                sreg_r <= sreg_r;
            end
            if (lock_hit_s) begin
                beat_cnt_r <= '0;
            end else if (rx_en && (state_r == LOCKED)) begin
                beat_cnt_r <= boundary_s ? '0 : beat_cnt_r + BW'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (lock_hit_s || marker_hit_s || lost_s) begin
                timeout_r <= '0;
            end else if (deliver_s) begin
                timeout_r <= timeout_r + TW'(1);
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Registered data path, status pulses and lock-loss counter
    always_ff @(posedge inclk or negedge rx_irstb) begin
        if (!rx_irstb) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            marker_seen  <= 1'b0;
            lock_lost    <= 1'b0;
            lock_err_cnt <= 8'd0;
        end else begin
            rx_valid    <= deliver_s;
            marker_seen <= lock_hit_s | marker_hit_s;
            lock_lost   <= lost_s;
            if (deliver_s) begin
                rx_data <= sreg_r;
            end else begin
                rx_data <= rx_data;
            end
            if (err_clr) begin
                lock_err_cnt <= 8'd0;
            end else if (lost_s && (lock_err_cnt != 8'hFF)) begin
                lock_err_cnt <= lock_err_cnt + 8'd1;
            end else begin
                lock_err_cnt <= lock_err_cnt;
            end
        end
    end

endmodule

// File: tb/tb_itrx_aib_phy_rx_lane_deser.sv
// Directed bench for the RX lane deserializer: lock, data, marker alignment,
// timeout with err_clr, rx_en drop and asynchronous reset.
module tb_itrx_aib_phy_rx_lane_deser;

    logic       inclk;
    logic       rx_irstb;
    logic       rx_en;
    logic       odat0;
    logic       odat1;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_locked;
    logic       marker_seen;
    logic       lock_lost;
    logic [7:0] lock_err_cnt;

    int         checks;
    int         errors;
    int         valid_cnt;
    int         marker_cnt;
    int         lost_cnt;
    logic [7:0] last_data;

    itrx_aib_phy_rx_lane_deser #(
        .DWIDTH(8),
        .MARKER(8'hA5),
        .LOCK_TIMEOUT(4)
    ) dut (
        .inclk(inclk),
        .rx_irstb(rx_irstb),
        .rx_en(rx_en),
        .odat0(odat0),
        .odat1(odat1),
        .err_clr(err_clr),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_locked(rx_locked),
        .marker_seen(marker_seen),
        .lock_lost(lock_lost),
        .lock_err_cnt(lock_err_cnt)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    task automatic clr_obs();
        valid_cnt  = 0;
        marker_cnt = 0;
        lost_cnt   = 0;
    endtask

    // One DDR beat per clock; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic en, input logic a, input logic b);
        rx_en = en;
        odat0 = a;
        odat1 = b;
        @(posedge inclk);
        #1;
        if (rx_valid) begin
            valid_cnt++;
            last_data = rx_data;
        end
        if (marker_seen) marker_cnt++;
        if (lock_lost) lost_cnt++;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 3; i >= 0; i--) step(1'b1, w[2*i+1], w[2*i]);
    endtask

    task automatic test_reset();
        rx_irstb = 1'b0;
        rx_en    = 1'b0;
        odat0    = 1'b0;
        odat1    = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge inclk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b exp 0", rx_valid); end
        checks++; if (rx_locked !== 1'b0) begin errors++; $display("FAIL reset_rx_locked: got %b exp 0", rx_locked); end
        checks++; if (marker_seen !== 1'b0) begin errors++; $display("FAIL reset_marker_seen: got %b exp 0", marker_seen); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost: got %b exp 0", lock_lost); end
        checks++; if (lock_err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h exp 00", lock_err_cnt); end
        rx_irstb = 1'b1;
    endtask

    task automatic test_lock();
        clr_obs();
        send_word(8'hA5);
        checks++; if (rx_locked !== 1'b0) begin errors++; $display("FAIL lock_before: got %b exp 0", rx_locked); end
        step(1'b1, 1'b0, 1'b0);
        checks++; if (rx_locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b exp 1", rx_locked); end
        checks++; if (marker_seen !== 1'b1) begin errors++; $display("FAIL lock_marker_seen: got %b exp 1", marker_seen); end
    endtask

    task automatic test_data();
        clr_obs();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL data_early_valid: got %0d exp 0", valid_cnt); end
        step(1'b1, 1'b1, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL data_valid: got %b exp 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL data_word: got %h exp 3c", rx_data); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL data_one_pulse: got %0d exp 1", valid_cnt); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL data_hold: got %h exp 3c", rx_data); end
    endtask

    task automatic test_off_boundary();
        clr_obs();
        step(1'b1, 1'b0, 1'b1);
        checks++; if (rx_data !== 8'hCA) begin errors++; $display("FAIL offb_first_word: got %h exp ca", rx_data); end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++; if (valid_cnt != 2) begin errors++; $display("FAIL offb_valid_cnt: got %0d exp 2", valid_cnt); end
        checks++; if (last_data !== 8'h50) begin errors++; $display("FAIL offb_second_word: got %h exp 50", last_data); end
        checks++; if (marker_cnt != 0) begin errors++; $display("FAIL offb_marker: got %0d exp 0", marker_cnt); end
        checks++; if (rx_locked !== 1'b1) begin errors++; $display("FAIL offb_locked: got %b exp 1", rx_locked); end
    endtask

    task automatic test_marker_boundary();
        clr_obs();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (marker_seen !== 1'b1) begin errors++; $display("FAIL mark_seen: got %b exp 1", marker_seen); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL mark_no_valid: got %0d exp 0", valid_cnt); end
        checks++; if (rx_data !== 8'h50) begin errors++; $display("FAIL mark_data_hold: got %h exp 50", rx_data); end
    endtask

    task automatic test_timeout();
        clr_obs();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        checks++; if (valid_cnt != 3) begin errors++; $display("FAIL to_valid_cnt: got %0d exp 3", valid_cnt); end
        checks++; if (lost_cnt != 0 || rx_locked !== 1'b1) begin errors++; $display("FAIL to_early_loss: lost %0d locked %b exp 0 1", lost_cnt, rx_locked); end
        step(1'b1, 1'b1, 1'b0);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h44) begin errors++; $display("FAIL to_last_word: valid %b data %h exp 1 44", rx_valid, rx_data); end
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL to_lock_lost: got %b exp 1", lock_lost); end
        checks++; if (rx_locked !== 1'b0) begin errors++; $display("FAIL to_unlocked: got %b exp 0", rx_locked); end
        checks++; if (lock_err_cnt !== 8'd1) begin errors++; $display("FAIL to_err_cnt: got %0d exp 1", lock_err_cnt); end
    endtask

    task automatic test_err_clr();
        clr_obs();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (rx_locked !== 1'b1) begin errors++; $display("FAIL clr_relock: got %b exp 1", rx_locked); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        send_word(8'h02);
        send_word(8'h03);
        send_word(8'h04);
        err_clr = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL clr_lock_lost: got %b exp 1", lock_lost); end
        checks++; if (lock_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_priority: got %0d exp 0", lock_err_cnt); end
        checks++; if (valid_cnt != 4 || rx_data !== 8'h04) begin errors++; $display("FAIL clr_words: cnt %0d data %h exp 4 04", valid_cnt, rx_data); end
    endtask

    task automatic test_en_drop();
        send_word(8'hA5);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (rx_locked !== 1'b1) begin errors++; $display("FAIL drop_locked: got %b exp 1", rx_locked); end
        clr_obs();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++; if (rx_locked !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b exp 0", rx_locked); end
        repeat (4) step(1'b0, 1'b1, 1'b0);
        send_word(8'hA5);
        checks++; if (rx_locked !== 1'b0) begin errors++; $display("FAIL drop_hunting: got %b exp 0", rx_locked); end
        step(1'b1, 1'b1, 1'b1);
        checks++; if (rx_locked !== 1'b1 || marker_seen !== 1'b1) begin errors++; $display("FAIL drop_relock: locked %b marker %b exp 1 1", rx_locked, marker_seen); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL drop_no_valid: got %0d exp 0", valid_cnt); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'h04 || rx_locked !== 1'b1) begin errors++; $display("FAIL ares_pre: data %h locked %b exp 04 1", rx_data, rx_locked); end
        #2;
        rx_irstb = 1'b0;
        #1;
        checks++; if (rx_locked !== 1'b0) begin errors++; $display("FAIL ares_locked: got %b exp 0", rx_locked); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL ares_data: got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0 || marker_seen !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL ares_pulses: got %b%b%b exp 000", rx_valid, marker_seen, lock_lost); end
        @(posedge inclk);
        #1;
        rx_irstb = 1'b1;
        clr_obs();
        repeat (6) step(1'b1, 1'b1, 1'b1);
        checks++; if (valid_cnt != 0 || rx_locked !== 1'b0) begin errors++; $display("FAIL ares_resume: valid %0d locked %b exp 0 0", valid_cnt, rx_locked); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_data = 8'h00;
        clr_obs();
        test_reset();
        test_lock();
        test_data();
        test_off_boundary();
        test_marker_boundary();
        test_timeout();
        test_err_clr();
        test_en_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
